// File: rtl/seg_instruction_fetch.sv
// seg_instruction_fetch
//   IF stage of the 5-stage MIPS pipeline. Holds the PC and a word-addressed
//   instruction memory (loaded through a debug write port), registers the
//   fetched instruction and PC+4 into the IF/ID latch, applies stall / jump /
//   flush requests coming back from ID, and halts the front end when the halt
//   word is fetched.
//
// Ports:
//   i_clk          clock, all state on rising edge
//   i_rst          asynchronous active-low reset
//   i_enable       global step enable; 0 freezes everything except mem writes
//   i_stall_flag   load-use stall: hold PC and IF/ID
//   i_jump_flag    redirect PC to i_PC_dir_jump (word aligned), inject bubble
//   i_PC_dir_jump  jump/branch target byte address
//   i_flush        advance PC, inject bubble into IF/ID
//   i_wr_en        instruction memory write strobe
//   i_wr_addr      word address to write
//   i_wr_data      word to write
//   o_PC           IF/ID latched PC+4 of the fetched instruction
//   o_instruction  IF/ID latched instruction
//   o_pc_current   current PC register
//   o_halt         fetch halted
module seg_instruction_fetch #(
  parameter int unsigned     LEN         = 32,
  parameter int unsigned     NB_ADDR_MEM = 10,
  parameter logic [LEN-1:0]  HALT_INSTR  = '1,
  parameter logic [LEN-1:0]  NOP_INSTR   = '0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_enable,
  input  logic                   i_stall_flag,
  input  logic                   i_jump_flag,
  input  logic [LEN-1:0]         i_PC_dir_jump,
  input  logic                   i_flush,
  input  logic                   i_wr_en,
  input  logic [NB_ADDR_MEM-1:0] i_wr_addr,
  input  logic [LEN-1:0]         i_wr_data,
  output logic [LEN-1:0]         o_PC,
  output logic [LEN-1:0]         o_instruction,
  output logic [LEN-1:0]         o_pc_current,
  output logic                   o_halt
);

  localparam int unsigned MEM_WORDS = 1 << NB_ADDR_MEM;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [LEN-1:0] pc_q, pc_d;
  logic [LEN-1:0] opc_d, instr_d;
  logic [LEN-1:0] pc_plus4;
  logic [LEN-1:0] fetch_word;
  logic [LEN-1:0] jump_target;

  logic [LEN-1:0] mem [MEM_WORDS];

  // No reset on the memory; a write is visible to fetch only after the edge,
  // so a same-cycle collision returns the old word.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Upper PC bits alias, byte offset bits are ignored.
  assign fetch_word  = mem[pc_q[NB_ADDR_MEM+1:2]];
  assign pc_plus4    = pc_q + LEN'(4);
  assign jump_target = i_PC_dir_jump & ~LEN'(3);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    opc_d   = o_PC;
    instr_d = o_instruction;
    if (i_enable) begin
      unique case (state_q)
        RUN: begin
          if (i_jump_flag) begin
            pc_d    = jump_target;
            instr_d = NOP_INSTR;
            opc_d   = '0;
          end else if (i_stall_flag) begin
            pc_d    = pc_q;
          end else if (i_flush) begin
            pc_d    = pc_plus4;
            instr_d = NOP_INSTR;
            opc_d   = '0;
          end else begin
            instr_d = fetch_word;
            opc_d   = pc_plus4;
            if (fetch_word == HALT_INSTR) begin
              // Halt word is latched but PC stays on it.
              state_d = HALTED;
            end else begin
              pc_d    = pc_plus4;
            end
          end
        end
        HALTED: begin
          instr_d = NOP_INSTR;
          opc_d   = '0;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q       <= RUN;
      pc_q          <= '0;
      o_PC          <= '0;
      o_instruction <= NOP_INSTR;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      o_PC          <= opc_d;
      o_instruction <= instr_d;
    end
  end

  assign o_pc_current = pc_q;
  assign o_halt       = (state_q == HALTED);

endmodule

// File: tb/tb_seg_instruction_fetch.sv
module tb_seg_instruction_fetch;

  localparam int unsigned LEN   = 32;
  localparam int unsigned NBA   = 10;
  localparam int unsigned WORDS = 1 << NBA;

  logic            i_clk;
  logic            i_rst;
  logic            i_enable;
  logic            i_stall_flag;
  logic            i_jump_flag;
  logic [LEN-1:0]  i_PC_dir_jump;
  logic            i_flush;
  logic            i_wr_en;
  logic [NBA-1:0]  i_wr_addr;
  logic [LEN-1:0]  i_wr_data;
  logic [LEN-1:0]  o_PC;
  logic [LEN-1:0]  o_instruction;
  logic [LEN-1:0]  o_pc_current;
  logic            o_halt;

  seg_instruction_fetch #(
    .LEN         (LEN),
    .NB_ADDR_MEM (NBA),
    .HALT_INSTR  (32'hFFFFFFFF),
    .NOP_INSTR   (32'h00000000)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_enable      (i_enable),
    .i_stall_flag  (i_stall_flag),
    .i_jump_flag   (i_jump_flag),
    .i_PC_dir_jump (i_PC_dir_jump),
    .i_flush       (i_flush),
    .i_wr_en       (i_wr_en),
    .i_wr_addr     (i_wr_addr),
    .i_wr_data     (i_wr_data),
    .o_PC          (o_PC),
    .o_instruction (o_instruction),
    .o_pc_current  (o_pc_current),
    .o_halt        (o_halt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] opc;
    logic [31:0] instr;
    logic        halt;
  } exp_t;

  exp_t sb[$];

  int unsigned n_tests;
  int unsigned n_fail;

  // Reference model state
  logic [31:0] m_mem [WORDS];
  logic [31:0] m_pc, m_opc, m_instr;
  logic        m_halt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = '0;
    m_opc   = '0;
    m_instr = '0;
    m_halt  = 1'b0;
  endtask

  task automatic clear_inputs();
    i_enable      = 1'b1;
    i_stall_flag  = 1'b0;
    i_jump_flag   = 1'b0;
    i_PC_dir_jump = '0;
    i_flush       = 1'b0;
    i_wr_en       = 1'b0;
    i_wr_addr     = '0;
    i_wr_data     = '0;
  endtask

  // Advance the model with the currently driven inputs, push the expectation,
  // take one clock edge, then pop and compare.
  task automatic cycle(input string tag);
    logic [31:0] fetched;
    exp_t e, g;
    fetched = m_mem[m_pc[NBA+1:2]];
    if (i_wr_en) m_mem[i_wr_addr] = i_wr_data;
    if (i_rst && i_enable) begin
      if (!m_halt) begin
        if (i_jump_flag) begin
          m_pc    = {i_PC_dir_jump[31:2], 2'b00};
          m_instr = '0;
          m_opc   = '0;
        end else if (i_stall_flag) begin
          m_pc    = m_pc;
        end else if (i_flush) begin
          m_pc    = m_pc + 32'd4;
          m_instr = '0;
          m_opc   = '0;
        end else begin
          m_instr = fetched;
          m_opc   = m_pc + 32'd4;
          if (fetched == 32'hFFFFFFFF) m_halt = 1'b1;
          else                         m_pc   = m_pc + 32'd4;
        end
      end else begin
        m_instr = '0;
        m_opc   = '0;
      end
    end
    e.pc = m_pc; e.opc = m_opc; e.instr = m_instr; e.halt = m_halt;
    sb.push_back(e);
    @(posedge i_clk);
    #1;
    if (sb.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      g = sb.pop_front();
      check_eq({tag, "_pc"},    o_pc_current,   g.pc);
      check_eq({tag, "_opc"},   o_PC,           g.opc);
      check_eq({tag, "_instr"}, o_instruction,  g.instr);
      check_eq({tag, "_halt"},  {31'd0, o_halt}, {31'd0, g.halt});
    end
    clear_inputs();
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_pc"},    o_pc_current,    32'd0);
    check_eq({tag, "_opc"},   o_PC,            32'd0);
    check_eq({tag, "_instr"}, o_instruction,   32'd0);
    check_eq({tag, "_halt"},  {31'd0, o_halt}, 32'd0);
  endtask

  task automatic write_word(input int unsigned addr, input logic [31:0] data, input string tag);
    i_wr_en   = 1'b1;
    i_wr_addr = NBA'(addr);
    i_wr_data = data;
    cycle(tag);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clear_inputs();
    i_rst = 1'b0;
    model_reset();
    #1;
    check_reset_state("reset0");

    // Load the whole memory under reset so every fetch has a known word.
    for (int unsigned i = 0; i < WORDS; i++) begin
      write_word(i, 32'h0100_0005 + i * 32'h0001_0003, "load");
    end
    write_word(0, 32'h01094020, "load0");
    write_word(1, 32'h8C220004, "load1");
    write_word(2, 32'hAC220008, "load2");
    write_word(3, 32'h00000000, "load3");
    check_reset_state("reset_hold");

    i_rst = 1'b1;
    // Sequential fetch
    for (int unsigned i = 0; i < 4; i++) cycle("seq");
    // Restart at 0 and stall while 0x8C220004 sits in IF/ID
    i_jump_flag = 1'b1; i_PC_dir_jump = 32'h0; cycle("jmp0");
    cycle("seqA"); cycle("seqB");
    check_eq("stall_pre_instr", o_instruction, 32'h8C220004);
    i_stall_flag = 1'b1; cycle("stall1");
    i_stall_flag = 1'b1; cycle("stall2");
    check_eq("stall_hold_pc", o_pc_current, 32'd8);
    cycle("after_stall");
    check_eq("after_stall_instr", o_instruction, 32'hAC220008);
    // Jump beats stall; low bits of target dropped
    i_jump_flag = 1'b1; i_stall_flag = 1'b1; i_PC_dir_jump = 32'h00000022;
    cycle("jmp_stall");
    check_eq("jmp_target", o_pc_current, 32'h20);
    cycle("after_jmp");
    // Flush at PC=4
    i_jump_flag = 1'b1; i_PC_dir_jump = 32'h4; cycle("jmp4");
    i_flush = 1'b1; cycle("flush");
    check_eq("flush_pc", o_pc_current, 32'd8);
    cycle("after_flush");
    check_eq("after_flush_instr", o_instruction, 32'hAC220008);
    // Enable low freezes state but memory writes still land
    i_enable = 1'b0; i_jump_flag = 1'b1; i_PC_dir_jump = 32'h40;
    i_wr_en = 1'b1; i_wr_addr = 10'd3; i_wr_data = 32'h33333333;
    cycle("en_low");
    i_enable = 1'b0; i_flush = 1'b1; cycle("en_low2");
    cycle("post_en");
    // Write/fetch collision at PC=0
    write_word(0, 32'h11111111, "pre_coll");
    i_jump_flag = 1'b1; i_PC_dir_jump = 32'h0; cycle("jmp_coll");
    write_word(0, 32'h22222222, "coll");
    check_eq("coll_old_word", o_instruction, 32'h11111111);
    i_jump_flag = 1'b1; i_PC_dir_jump = 32'h0; cycle("jmp_back");
    cycle("coll_new");
    check_eq("coll_new_word", o_instruction, 32'h22222222);
    // PC wrap and address aliasing
    i_jump_flag = 1'b1; i_PC_dir_jump = 32'hFFFFFFFE; cycle("jmp_top");
    cycle("wrap");
    check_eq("wrap_pc", o_pc_current, 32'h0);
    i_jump_flag = 1'b1; i_PC_dir_jump = 32'h0000_1004; cycle("jmp_alias");
    cycle("alias");
    // Random mix
    for (int unsigned i = 0; i < 300; i++) begin
      i_enable      = ($urandom_range(0, 7) != 0);
      i_stall_flag  = ($urandom_range(0, 5) == 0);
      i_jump_flag   = ($urandom_range(0, 7) == 0);
      i_PC_dir_jump = $urandom;
      i_flush       = ($urandom_range(0, 6) == 0);
      i_wr_en       = ($urandom_range(0, 3) == 0);
      i_wr_addr     = NBA'($urandom);
      i_wr_data     = $urandom & 32'h7FFFFFFF;
      cycle("rand");
    end
    // Halt
    write_word(5, 32'hFFFFFFFF, "halt_load");
    i_jump_flag = 1'b1; i_PC_dir_jump = 32'h14; cycle("jmp_halt");
    cycle("halt_fetch");
    check_eq("halt_instr", o_instruction, 32'hFFFFFFFF);
    check_eq("halt_flag", {31'd0, o_halt}, 32'd1);
    cycle("halt_drain");
    i_jump_flag = 1'b1; i_PC_dir_jump = 32'h100; cycle("halt_jmp");
    i_flush = 1'b1; i_stall_flag = 1'b1; cycle("halt_flush");
    i_enable = 1'b0; cycle("halt_en_low");
    check_eq("halt_pc_frozen", o_pc_current, 32'h14);
    // Async reset mid-cycle
    #2;
    i_rst = 1'b0;
    #1;
    model_reset();
    check_reset_state("async_rst");
    cycle("rst_hold");
    i_rst = 1'b1;
    for (int unsigned i = 0; i < 6; i++) cycle("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_instruction_fetch.md
Name: seg_instruction_fetch

Overview:
IF stage of the 5-stage MIPS pipeline; the upstream end of the IF/ID interface consumed by seg_instruction_decode.
- Holds the PC and a word-addressed instruction memory, loaded through a debug write port.
- Registers the fetched instruction and PC+4 into the IF/ID latch.
- Applies stall, jump redirect and flush requests returned from ID.
- Halts the front end when the halt word is fetched.

Parameters:
LEN, 32, datapath/PC/instruction width
NB_ADDR_MEM, 10, instruction memory word-address width (1024 words)
HALT_INSTR, 32'hFFFFFFFF, instruction word that halts fetch
NOP_INSTR, 32'h00000000, bubble injected on flush/jump/halt

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  asynchronous, active-low reset
i_enable  in  1  global step enable; 0 freezes all state
i_stall_flag  in  1  load-use stall from ID; hold PC and IF/ID
i_jump_flag  in  1  ID resolved a jump/taken branch
i_PC_dir_jump  in  LEN  jump/branch target byte address
i_flush  in  1  replace IF/ID contents with bubble
i_wr_en  in  1  instruction memory write strobe
i_wr_addr  in  NB_ADDR_MEM  word address to write
i_wr_data  in  LEN  word to write
o_PC  out  LEN  IF/ID latched PC+4 of fetched instruction
o_instruction  out  LEN  IF/ID latched instruction
o_pc_current  out  LEN  current PC register (debug)
o_halt  out  1  fetch halted

Behaviour:
- Reset (i_rst=0, async):
  - PC=0, o_PC=0, o_instruction=NOP_INSTR, o_halt=0, state=RUN.
  - Memory contents are not reset.
- Memory read: combinational mem[PC[NB_ADDR_MEM+1:2]]. PC bits above NB_ADDR_MEM+1 alias. PC[1:0] are ignored.
- Memory write: synchronous on i_wr_en, independent of i_enable and state.
  - A write to the address being fetched in the same cycle is not visible until the next cycle; the fetch gets the old word.
- FSM states RUN, HALTED. Each rising edge with i_enable=1 in RUN, priority is highest first:
  1. i_jump_flag=1: PC<=i_PC_dir_jump with bits[1:0] forced to 0; o_instruction<=NOP; o_PC<=0. Jump overrides stall and flush.
  2. i_stall_flag=1: PC, o_PC and o_instruction hold.
  3. i_flush=1: PC<=PC+4; o_instruction<=NOP; o_PC<=0.
  4. Normal: o_instruction<=mem word; o_PC<=PC+4; PC<=PC+4.
     - If the fetched word==HALT_INSTR: it is latched into IF/ID, PC is NOT incremented, and state<=HALTED.
- HALTED:
  - PC frozen; o_instruction<=NOP and o_PC<=0 every enabled cycle (pipeline drains).
  - o_halt=1, registered, asserted starting the same edge that latches the halt word.
  - Jump, stall and flush are ignored. Exit only by reset.
- i_enable=0: no state changes except memory writes.
- PC arithmetic is modulo 2^LEN; PC+4 at 32'hFFFFFFFC wraps to 0.
- Latency: instruction at address A appears on o_instruction one edge after PC==A, with o_PC=A+4.
- Reset asserted mid-operation clears everything immediately, including HALTED.

Test Plan:
- Load mem[0..3] = 0x01094020, 0x8C220004, 0xAC220008, 0x00000000 via the write port; release reset with enable=1 → o_instruction sequence 0x01094020, 0x8C220004, 0xAC220008, 0x0 with o_PC = 4, 8, 12, 16.
- Stall: assert i_stall_flag for 2 cycles while o_instruction=0x8C220004 → o_instruction/o_PC hold 0x8C220004/8 and o_pc_current holds 8. Release → next is 0xAC220008/12.
- Jump: i_jump_flag=1 with i_PC_dir_jump=0x00000022 while PC=8, stall also high → next edge o_instruction=NOP, o_pc_current=0x20. Following edge fetches mem[8].
- Flush: i_flush=1 at PC=4 → o_instruction=NOP, o_PC=0, o_pc_current=8. Then mem[2] is fetched normally.
- Halt: mem[1]=0xFFFFFFFF → o_instruction=0xFFFFFFFF, o_halt=1, o_pc_current stays 4. Next edges give NOP. A jump request leaves PC unchanged. Async reset → o_halt=0, PC=0.
- Write/fetch collision: PC=0, mem[0]=0x11111111, write mem[0]=0x22222222 on the same edge → o_instruction=0x11111111. A jump back to 0 later fetches 0x22222222.
